// File: rtl/trig_la_pkg.sv
// trig_la_pkg: shared state and trigger-mode encodings for the triggered logic analyzer.
package trig_la_pkg;
    typedef enum logic [2:0] {IDLE, PRETRIG, WAIT_TRIG, POST, DONE} la_state_e;
    typedef enum logic [1:0] {
        TRIG_LEVEL = 2'b00,
        TRIG_ENTER = 2'b01,
        TRIG_LEAVE = 2'b10,
        TRIG_FORCE = 2'b11
    } trig_mode_e;
endpackage

// File: rtl/la_sample_ram.sv
// la_sample_ram: DEPTH x WIDTH sample store, synchronous write, registered read that holds when idle.
module la_sample_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/trig_logic_analyzer.sv
// trig_logic_analyzer: captures a probe bus into a circular buffer around a programmable trigger
// and reads it back oldest-first once the capture is frozen.
module trig_logic_analyzer
    import trig_la_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int PRE_TRIG = 4,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [WIDTH-1:0] probe,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [WIDTH-1:0] trig_value,
    input  logic [1:0]       trig_mode,
    output logic             busy,
    output logic             triggered,
    output logic             done,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);
    localparam logic [AW-1:0] PRE_N = AW'(PRE_TRIG);
    localparam logic [AW-1:0] PRE_LAST = AW'(PRE_TRIG - 1);
    localparam logic [AW-1:0] POST_N = AW'(DEPTH - PRE_TRIG - 1);
    la_state_e state;
    trig_mode_e mode;
    logic [AW-1:0] wr_ptr, trig_ptr, cnt, raddr;
    logic match, match_q, hit, we, re;
    always_comb begin
        mode = trig_mode_e'(trig_mode);
        match = ((probe ^ trig_value) & trig_mask) == '0;
        hit = mode == TRIG_LEVEL ? match :
              mode == TRIG_ENTER ? match && !match_q :
              mode == TRIG_LEAVE ? !match && match_q : 1'b1;
    end
    assign we = state inside {PRETRIG, WAIT_TRIG, POST};
    assign re = rd_en && state == DONE;
    // Logical index 0 is PRE_TRIG entries behind the trigger sample.
    assign raddr = trig_ptr - PRE_N + rd_addr;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wr_ptr <= '0;
            trig_ptr <= '0;
            cnt <= '0;
            match_q <= 1'b0;
            busy <= 1'b0;
            triggered <= 1'b0;
            done <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            match_q <= match;
            rd_valid <= re;
            case (state)
                IDLE, DONE: if (arm) begin
                    state <= PRE_TRIG == 0 ? WAIT_TRIG : PRETRIG;
                    wr_ptr <= '0;
                    cnt <= '0;
                    triggered <= 1'b0;
                    busy <= 1'b1;
                    done <= 1'b0;
                end
                PRETRIG: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    cnt <= cnt + 1'b1;
                    if (cnt == PRE_LAST) state <= WAIT_TRIG;
                end
                WAIT_TRIG: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (hit) begin
                        trig_ptr <= wr_ptr;
                        triggered <= 1'b1;
                        cnt <= POST_N;
                        state <= POST_N == '0 ? DONE : POST;
                        busy <= POST_N != '0;
                        done <= POST_N == '0;
                    end
                end
                POST: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    cnt <= cnt - 1'b1;
                    if (cnt == AW'(1)) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    la_sample_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk(clk),
        .rst(rst),
        .we(we),
        .waddr(wr_ptr),
        .wdata(probe),
        .re(re),
        .raddr(raddr),
        .rdata(rd_data)
    );
endmodule

// File: tb/tb_trig_logic_analyzer.sv
// tb_trig_logic_analyzer: directed captures checked against a sample-history model and literal expectations.
module tb_trig_logic_analyzer;
    localparam int W = 16;
    localparam int D = 16;
    localparam int P = 4;
    logic clk = 0, rst = 1, arm = 0, rd_en = 0;
    logic [W-1:0] probe = 0, trig_mask = 0, trig_value = 0;
    logic [1:0] trig_mode = 0;
    logic [3:0] rd_addr = 0;
    logic busy, triggered, done, rd_valid;
    logic [W-1:0] rd_data;
    bit run = 1;
    int n_chk = 0, n_pass = 0;

    trig_logic_analyzer #(.WIDTH(W), .DEPTH(D), .PRE_TRIG(P)) dut (
        .clk(clk), .rst(rst), .arm(arm), .probe(probe), .trig_mask(trig_mask),
        .trig_value(trig_value), .trig_mode(trig_mode), .busy(busy), .triggered(triggered),
        .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Model: keep every sample since arm, locate the trigger by rule, slice the window at completion.
    bit m_act = 0, m_trig = 0, m_done = 0, m_mq = 0, m_valid = 0;
    logic [W-1:0] m_data = 0;
    logic [W-1:0] hist[$];
    logic [W-1:0] m_buf[D];
    int tidx = 0;

    function automatic bit fires(input logic [1:0] md, input bit m, input bit mq);
        case (md)
            2'd0: return m;
            2'd1: return m && !mq;
            2'd2: return !m && mq;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk) begin
        bit m;
        m = ((probe ^ trig_value) & trig_mask) == 0;
        if (rst) begin
            m_act = 0; m_trig = 0; m_done = 0; m_mq = 0; m_valid = 0; m_data = 0;
        end else begin
            m_valid = rd_en && m_done;
            if (m_valid) m_data = m_buf[rd_addr];
            if (m_act) begin
                hist.push_back(probe);
                if (!m_trig && hist.size() > P && fires(trig_mode, m, m_mq)) begin
                    m_trig = 1;
                    tidx = hist.size() - 1;
                end
                if (m_trig && hist.size() - 1 - tidx == D - P - 1) begin
                    m_act = 0;
                    m_done = 1;
                    for (int i = 0; i < D; i++) m_buf[i] = hist[tidx - P + i];
                end
            end else if (arm) begin
                m_act = 1; m_trig = 0; m_done = 0;
                hist.delete();
            end
            m_mq = m;
        end
    end

    always @(negedge clk) begin
        chk("busy", {15'b0, busy}, {15'b0, m_act});
        chk("triggered", {15'b0, triggered}, {15'b0, m_trig});
        chk("done", {15'b0, done}, {15'b0, m_done});
        chk("rd_valid", {15'b0, rd_valid}, {15'b0, m_valid});
        chk("rd_data", rd_data, m_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (run) probe = probe + 1'b1;
    endtask

    task automatic do_arm(input logic [W-1:0] p0);
        arm = 1;
        probe = p0;
        tick();
        arm = 0;
    endtask

    task automatic set_trig(input logic [W-1:0] mk, input logic [W-1:0] v, input logic [1:0] md);
        trig_mask = mk;
        trig_value = v;
        trig_mode = md;
    endtask

    task automatic wait_trig(input logic [W-1:0] exp_probe);
        int k = 0;
        while (!triggered && k < 400) begin tick(); k++; end
        chk("trig_probe", probe, exp_probe);
    endtask

    task automatic wait_done(input logic [W-1:0] exp_probe);
        int k = 0;
        while (!done && k < 400) begin tick(); k++; end
        chk("done_probe", probe, exp_probe);
    endtask

    task automatic read_one(input logic [3:0] a, input logic [W-1:0] exp);
        rd_en = 1;
        rd_addr = a;
        tick();
        rd_en = 0;
        chk("lit_rd_valid", {15'b0, rd_valid}, 16'd1);
        chk("lit_rd_data", rd_data, exp);
    endtask

    task automatic read_all(input logic [W-1:0] base);
        for (int i = 0; i < D; i++) begin
            rd_en = 1;
            rd_addr = 4'(i);
            tick();
            chk("lit_rd_valid", {15'b0, rd_valid}, 16'd1);
            chk("lit_rd_data", rd_data, W'(base + W'(i)));
        end
        rd_en = 0;
    endtask

    initial begin
        repeat (3) tick();
        rst = 0;
        set_trig(16'hFFFF, 16'h0020, 2'd0);
        do_arm(0);
        repeat (5) tick();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        chk("rst_busy", {15'b0, busy}, 16'd0);
        chk("rst_triggered", {15'b0, triggered}, 16'd0);
        chk("rst_done", {15'b0, done}, 16'd0);
        chk("rst_rd_valid", {15'b0, rd_valid}, 16'd0);
        do_arm(0);
        chk("busy_after_arm", {15'b0, busy}, 16'd1);
        wait_trig(16'h0021);
        wait_done(16'h002C);
        read_all(16'h001C);

        set_trig(16'h00FF, 16'h0033, 2'd1);
        do_arm(0);
        wait_trig(16'h0034);
        wait_done(16'h003F);
        read_all(16'h002F);

        run = 0;
        do_arm(16'h0033);
        repeat (10) tick();
        chk("hold_no_trig", {15'b0, triggered}, 16'd0);
        probe = 0;
        tick();
        probe = 16'h0133;
        run = 1;
        wait_trig(16'h0134);
        wait_done(16'h013F);
        read_one(4'd3, 16'h0000);
        read_one(4'd4, 16'h0133);
        read_one(4'd15, 16'h013E);

        set_trig(16'h00FF, 16'h0033, 2'd2);
        do_arm(0);
        wait_trig(16'h0035);
        wait_done(16'h0040);
        read_all(16'h0030);

        set_trig(16'h0000, 16'h0000, 2'd3);
        do_arm(0);
        wait_trig(16'h0006);
        wait_done(16'h0011);
        read_all(16'h0001);

        set_trig(16'hFFFF, 16'h0040, 2'd0);
        do_arm(0);
        wait_trig(16'h0041);
        wait_done(16'h004C);
        read_all(16'h003C);

        set_trig(16'hFFFF, 16'h0020, 2'd0);
        do_arm(0);
        wait_trig(16'h0021);
        tick();
        arm = 1;
        tick();
        arm = 0;
        wait_done(16'h002C);
        read_all(16'h001C);

        do_arm(0);
        rd_en = 1;
        rd_addr = 4'd4;
        repeat (3) begin
            tick();
            chk("early_rd_valid", {15'b0, rd_valid}, 16'd0);
        end
        rd_en = 0;
        wait_trig(16'h0021);
        repeat (3) tick();
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("no_done_after_rst", {15'b0, done}, 16'd0);
        end
        do_arm(0);
        wait_trig(16'h0021);
        wait_done(16'h002C);
        read_all(16'h001C);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
